// File: rtl/register_bank.sv
// Parameterised register file with optional zero register, write-to-read bypass
// and a handshaked dump sequencer that streams a snapshot of every register.

module register_bank_read #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] mem,
    input  logic [ADDR_WIDTH-1:0]                    readAddr,
    input  logic                                     regWrite,
    input  logic [ADDR_WIDTH-1:0]                    writeAddr,
    input  logic [DATA_WIDTH-1:0]                    writeData,
    output logic [DATA_WIDTH-1:0]                    readData
);
    always_comb begin
        readData = mem[readAddr];
        if (ZERO_REG != 0 && readAddr == '0)
            readData = '0;
        else if (BYPASS != 0 && regWrite && writeAddr == readAddr)
            readData = writeData;
    end
endmodule

module register_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           Clock,
    input  logic                           Reset_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ReadRegister,
    output logic [NUM_READ*DATA_WIDTH-1:0] ReadData,
    input  logic [ADDR_WIDTH-1:0]          WriteRegister,
    input  logic [DATA_WIDTH-1:0]          WriteData,
    input  logic                           RegWrite,
    input  logic                           dump_start,
    output logic                           dump_busy,
    output logic                           dump_valid,
    input  logic                           dump_ready,
    output logic [ADDR_WIDTH-1:0]          dump_addr,
    output logic [DATA_WIDTH-1:0]          dump_data,
    output logic                           dump_done
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} dumpState_t;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic                             writeEn;
    dumpState_t                       state, nextState;
    logic                             loadEn;
    logic [ADDR_WIDTH-1:0]            loadIdx;
    logic [DATA_WIDTH-1:0]            loadVal;

    assign writeEn = RegWrite && !(ZERO_REG != 0 && WriteRegister == '0);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            mem <= '0;
        else if (writeEn)
            mem[WriteRegister] <= WriteData;
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : gRead
        register_bank_read #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .ZERO_REG  (ZERO_REG),
            .BYPASS    (BYPASS)
        ) uRead (
            .mem      (mem),
            .readAddr (ReadRegister[k*ADDR_WIDTH +: ADDR_WIDTH]),
            .regWrite (RegWrite),
            .writeAddr(WriteRegister),
            .writeData(WriteData),
            .readData (ReadData[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Snapshot is the post-edge value, so a same-edge write is always captured.
    always_comb begin
        loadVal = mem[loadIdx];
        if (ZERO_REG != 0 && loadIdx == '0)
            loadVal = '0;
        else if (writeEn && WriteRegister == loadIdx)
            loadVal = WriteData;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState  = state;
        loadEn     = 1'b0;
        loadIdx    = '0;
        dump_valid = 1'b0;
        dump_done  = 1'b0;
        dump_busy  = 1'b0;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    nextState = SEND;
                    loadEn    = 1'b1;
                end
            end
            SEND: begin
                dump_valid = 1'b1;
                dump_busy  = 1'b1;
                if (dump_ready) begin
                    if (dump_addr == LAST_IDX) begin
                        nextState = DONE;
                    end else begin
                        loadEn  = 1'b1;
                        loadIdx = dump_addr + 1'b1;
                    end
                end
            end
            DONE: begin
                dump_done = 1'b1;
                dump_busy = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            dump_addr <= '0;
            dump_data <= '0;
        end else if (loadEn) begin
            dump_addr <= loadIdx;
            dump_data <= loadVal;
        end
    end
endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: reset, zero register, bypass on/off,
// four read ports, full dump, stalled dump and reset in the middle of a dump.

module tb_register_bank;
    localparam int DW = 32;
    localparam int AW = 5;

    logic            Clock = 1'b0;
    logic            Reset_n = 1'b0;
    logic [4*AW-1:0] ReadRegister = '0;
    logic [4*DW-1:0] ReadData;
    logic [AW-1:0]   WriteRegister = '0;
    logic [DW-1:0]   WriteData = '0;
    logic            RegWrite = 1'b0;
    logic            dump_start = 1'b0;
    logic            dump_busy, dump_valid, dump_done;
    logic            dump_ready = 1'b0;
    logic [AW-1:0]   dump_addr;
    logic [DW-1:0]   dump_data;

    // Second instance without bypass shares the write/read stimulus.
    logic [2*DW-1:0] nbReadData;
    logic            nbStart = 1'b0, nbReady = 1'b0;
    logic            nbBusy, nbValid, nbDone;
    logic [AW-1:0]   nbAddr;
    logic [DW-1:0]   nbData;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    register_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(4), .ZERO_REG(1), .BYPASS(1)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .ReadRegister(ReadRegister), .ReadData(ReadData),
        .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
    );

    register_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(2), .ZERO_REG(1), .BYPASS(0)) dutNb (
        .Clock(Clock), .Reset_n(Reset_n), .ReadRegister(ReadRegister[2*AW-1:0]), .ReadData(nbReadData),
        .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
        .dump_start(nbStart), .dump_busy(nbBusy), .dump_valid(nbValid),
        .dump_ready(nbReady), .dump_addr(nbAddr), .dump_data(nbData), .dump_done(nbDone)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic setRead(input int p, input logic [AW-1:0] a);
        ReadRegister[p*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] rd(input int p);
        return ReadData[p*DW +: DW];
    endfunction

    task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        WriteRegister = a;
        WriteData     = d;
        RegWrite      = 1'b1;
        tick();
        RegWrite      = 1'b0;
    endtask

    initial begin
        int n;
        logic [DW-1:0] exp;

        // Reset state
        #1;
        chk("rst_busy", dump_busy, 0);
        chk("rst_valid", dump_valid, 0);
        chk("rst_done", dump_done, 0);
        chk("rst_addr", dump_addr, 0);
        chk("rst_data", dump_data, 0);
        #2 Reset_n = 1'b1;
        tick();

        for (int a = 0; a < 32; a++) begin
            setRead(0, AW'(a));
            setRead(1, AW'(a));
            #1;
            chk($sformatf("rst_rd0_%0d", a), rd(0), 0);
            chk($sformatf("rst_rd1_%0d", a), rd(1), 0);
        end

        // Zero register ignores writes, even through bypass
        setRead(0, 0);
        WriteRegister = 0; WriteData = 32'hDEADBEEF; RegWrite = 1'b1;
        #1;
        chk("r0_bypass", rd(0), 0);
        tick();
        RegWrite = 1'b0;
        #1;
        chk("r0_after", rd(0), 0);

        // Bypass vs no bypass on r9
        setRead(0, 9);
        WriteRegister = 9; WriteData = 32'h12345678; RegWrite = 1'b1;
        #1;
        chk("byp_same", rd(0), 32'h12345678);
        chk("nobyp_same", nbReadData[DW-1:0], 0);
        tick();
        RegWrite = 1'b0;
        #1;
        chk("byp_next", rd(0), 32'h12345678);
        chk("nobyp_next", nbReadData[DW-1:0], 32'h12345678);

        // Four ports
        doWrite(1, 10);
        doWrite(2, 20);
        doWrite(3, 30);
        doWrite(4, 40);
        setRead(0, 4); setRead(1, 3); setRead(2, 2); setRead(3, 1);
        #1;
        chk("p0", rd(0), 40);
        chk("p1", rd(1), 30);
        chk("p2", rd(2), 20);
        chk("p3", rd(3), 10);

        // Preload rN = 3N and stream everything
        for (int i = 0; i < 32; i++) doWrite(AW'(i), DW'(i * 3));
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("d1_busy", dump_busy, 1);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("d1_valid_%0d", i), dump_valid, 1);
            chk($sformatf("d1_addr_%0d", i), dump_addr, i);
            chk($sformatf("d1_data_%0d", i), dump_data, i * 3);
            tick();
        end
        chk("d1_done", dump_done, 1);
        chk("d1_valid_end", dump_valid, 0);
        chk("d1_busy_done", dump_busy, 1);
        dump_start = 1'b1;   // ignored in DONE
        tick();
        dump_start = 1'b0;
        chk("d1_done_off", dump_done, 0);
        chk("d1_busy_off", dump_busy, 0);
        tick();
        chk("d1_no_restart", dump_valid, 0);

        // Stalled dump with a write to the held index
        dump_ready = 1'b0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("d2_addr0", dump_addr, 0);
        chk("d2_data0", dump_data, 0);
        dump_ready = 1'b1;
        tick();
        chk("d2_addr1", dump_addr, 1);
        chk("d2_data1", dump_data, 3);
        dump_ready = 1'b0;
        WriteRegister = 1; WriteData = 32'hAAAA; RegWrite = 1'b1;
        dump_start = 1'b1;
        tick();
        RegWrite = 1'b0;
        dump_start = 1'b0;
        chk("d2_hold_addr_a", dump_addr, 1);
        chk("d2_hold_data_a", dump_data, 3);
        chk("d2_hold_valid", dump_valid, 1);
        tick();
        chk("d2_hold_addr_b", dump_addr, 1);
        chk("d2_hold_data_b", dump_data, 3);
        setRead(0, 1);
        #1;
        chk("d2_r1_written", rd(0), 32'hAAAA);
        dump_ready = 1'b1;
        tick();
        for (int i = 2; i < 32; i++) begin
            exp = (i == 6) ? 32'h5555 : DW'(i * 3);
            chk($sformatf("d2_addr_%0d", i), dump_addr, i);
            chk($sformatf("d2_data_%0d", i), dump_data, exp);
            if (i == 5) begin
                // write lands on the edge that loads entry 6
                WriteRegister = 6; WriteData = 32'h5555; RegWrite = 1'b1;
            end
            tick();
            RegWrite = 1'b0;
        end
        chk("d2_done", dump_done, 1);
        tick();
        chk("d2_busy_off", dump_busy, 0);
        tick();
        chk("d2_second_start_ignored", dump_valid, 0);

        // Reset in the middle of a dump
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        chk("d3_addr17", dump_addr, 17);
        chk("d3_data17", dump_data, 51);
        #2 Reset_n = 1'b0;
        #1;
        chk("d3_rst_valid", dump_valid, 0);
        chk("d3_rst_busy", dump_busy, 0);
        chk("d3_rst_data", dump_data, 0);
        chk("d3_rst_addr", dump_addr, 0);
        setRead(0, 6); setRead(1, 17); setRead(2, 31); setRead(3, 1);
        #1;
        for (int p = 0; p < 4; p++) chk($sformatf("d3_rst_rd%0d", p), rd(p), 0);
        tick();
        #2 Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("d3_no_done_%0d", i), dump_done, 0);
            chk($sformatf("d3_idle_%0d", i), dump_busy, 0);
        end
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("d4_valid", dump_valid, 1);
        chk("d4_addr0", dump_addr, 0);
        tick();
        chk("d4_addr1", dump_addr, 1);
        chk("d4_data1", dump_data, 0);
        n = 0;
        while (!dump_done && n < 40) begin
            tick();
            n++;
        end
        chk("d4_done_seen", dump_done, 1);
        tick();
        chk("d4_busy_off", dump_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_bank.md
# register_bank

Parametrised general-purpose register file for the MIPS datapath; successor to the fixed 32×32 two-read-port file. It adds a configurable width, depth and read-port count, an optional hardwired-zero register and same-cycle write-to-read bypass. It also has a handshaked dump sequencer that streams every register to the debug/UART unit. It sits in the ID stage; the dump port connects to the debug unit.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH
- NUM_READ, 2, number of combinational read ports (1..4)
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = a read of the register being written this cycle returns WriteData
- Clock  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- ReadRegister  in  NUM_READ*ADDR_WIDTH  read addresses; port k is at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- ReadData  out  NUM_READ*DATA_WIDTH  read data; port k is at bits [k*DATA_WIDTH +: DATA_WIDTH]
- WriteRegister  in  ADDR_WIDTH  write address
- WriteData  in  DATA_WIDTH  write data
- RegWrite  in  1  write enable
- dump_start  in  1  single-cycle request to stream all registers
- dump_busy  out  1  high from the accepted start until dump_done is deasserted
- dump_valid  out  1  dump_addr/dump_data hold a valid entry
- dump_ready  in  1  consumer accepts the entry
- dump_addr  out  ADDR_WIDTH  index of the current entry
- dump_data  out  DATA_WIDTH  snapshot value of the current entry
- dump_done  out  1  one-cycle pulse after the final entry is accepted

## Operation
- Storage: array of 2**ADDR_WIDTH words.
- Reset (Reset_n low, asynchronous): all words cleared to 0; FSM goes to IDLE. dump_busy, dump_valid and dump_done go to 0; dump_addr and dump_data go to 0.
- Write: on a rising edge with RegWrite=1, mem[WriteRegister] <= WriteData.
  - If ZERO_REG=1 and WriteRegister=0, the write is discarded.
- Read (combinational), per port k:
  - If ZERO_REG=1 and address=0: return 0.
  - Else if BYPASS=1, RegWrite=1 and WriteRegister equals the address: return WriteData.
  - Else: return mem[address].
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: dump_start=1 moves to SEND. Entry 0 is loaded: dump_addr=0, dump_data = read of index 0 with the read rules above applied, including bypass.
  - SEND: dump_valid=1. On an edge with dump_ready=1:
    - If dump_addr is not the last index, dump_addr increments and dump_data reloads from the new index.
    - If dump_addr is the last index, the FSM moves to DONE and dump_valid drops.
  - SEND with dump_ready=0: dump_addr and dump_data are held stable, even if that register is written meanwhile.
  - DONE: dump_done=1 for exactly one cycle, then IDLE.
- dump_busy = 1 in SEND and DONE.
- dump_start is ignored outside IDLE.
- RegWrite and all read ports stay fully functional during a dump; the dump never stalls writes.
- Entry-load value: the value the loaded index holds after the same edge's write. A write to that index on the load edge is captured (bypass path), independent of the BYPASS parameter.

## Timing
- Read latency 0 (combinational). Write becomes visible through mem on the cycle after the edge; with BYPASS=1 it is visible in the same cycle.
- dump_start sampled at edge t: dump_valid=1 with entry 0 from t to t+1.
- Throughput with dump_ready held at 1: one entry per cycle. A full dump is 2**ADDR_WIDTH cycles of SEND plus 1 cycle of DONE.
- Final handshake at edge e: dump_valid=0 and dump_done=1 during [e, e+1); dump_busy=0 from e+1.
- dump_start asserted during the DONE cycle is ignored; a new dump needs dump_start in IDLE.
- Reset_n low mid-dump: outputs clear immediately (asynchronous). After reset release the FSM is in IDLE and no dump_done is issued.

## Test plan
- Reset with defaults, then read ports 0 and 1 at every address -> all return 0. Write 0xDEADBEEF to r0 -> r0 still reads 0.
- Write 0x12345678 to r9 with ReadRegister port 0 = 9 in the same cycle:
  - BYPASS=1 -> 0x12345678 in that cycle.
  - BYPASS=0 -> old value 0 in that cycle, 0x12345678 the next cycle.
- NUM_READ=4: write r1..r4 = 10, 20, 30, 40, then read addresses {4,3,2,1} on the four ports -> {40,30,20,10}.
- Preload rN = N*3, pulse dump_start, hold dump_ready=1:
  - 32 consecutive entries with addr 0..31 and data 0, 3, ..., 93 (entry 0 = 0 because ZERO_REG=1).
  - dump_done pulses one cycle after the last entry; dump_busy drops the next cycle.
- Dump with dump_ready toggling 1,0,0,1 and a write of 0xAAAA to the held index while stalled:
  - dump_data unchanged while stalled.
  - Later entries are neither skipped nor duplicated.
  - A second dump_start while busy is ignored.
- Assert Reset_n low at entry 17 of a dump:
  - dump_valid, dump_busy and dump_data become 0 immediately, and all registers read 0.
  - No dump_done pulse appears.
  - A fresh dump afterwards starts at addr 0.
